// File: rtl/regfile_scoreboard_pkg.sv
// Shared sizing constants for the register-file scoreboard.
package regfile_scoreboard_pkg;

    localparam int SB_NREG  = 32;
    localparam int SB_ASIZE = 5;
    localparam int SB_PW    = 2;

endpackage

// File: rtl/regfile_scoreboard_sb_pend_cnt.sv
// Saturating up/down pending-write counter for one architectural register.
module sb_pend_cnt #(
    parameter int PW = 2
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          clr_i,
    input  logic          inc_i,
    input  logic          dec_i,
    output logic [PW-1:0] cnt_o,
    output logic          nz_o
);

    localparam logic [PW-1:0] CNT_MAX = '1;

    logic [PW-1:0] cnt_q;
    logic [PW-1:0] cnt_d;

    // Simultaneous inc and dec cancel; both directions hold at their limits.
    always_comb begin
        cnt_d = cnt_q;
        if (clr_i) begin
            cnt_d = '0;
        end else if (inc_i && !dec_i && cnt_q != CNT_MAX) begin
            cnt_d = cnt_q + PW'(1);
        end else if (dec_i && !inc_i && cnt_q != '0) begin
            cnt_d = cnt_q - PW'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign cnt_o = cnt_q;
    assign nz_o  = |cnt_q;

endmodule

// File: rtl/regfile_scoreboard.sv
// Pending-write scoreboard between decode and the regfile write port.
// Optional statistics counters enabled by defining SCOREBOARD_STATS_EN.
module regfile_scoreboard
    import regfile_scoreboard_pkg::*;
(
    input  logic                clk,
    input  logic                rst,
    input  logic                iss_valid,
    input  logic                iss_rs_use,
    input  logic [SB_ASIZE-1:0] iss_rs,
    input  logic                iss_rt_use,
    input  logic [SB_ASIZE-1:0] iss_rt,
    input  logic                iss_wen,
    input  logic [SB_ASIZE-1:0] iss_rd,
    input  logic                wb_wen,
    input  logic [SB_ASIZE-1:0] wb_waddr,
    input  logic                flush,
    output logic                stall,
    output logic                iss_accept,
    output logic [SB_NREG-1:0]  busy,
    output logic                sb_err
`ifdef SCOREBOARD_STATS_EN
    ,
    output logic [31:0]         stat_stall_cyc,
    output logic [31:0]         stat_issue_cnt
`endif
);

    localparam logic [SB_PW-1:0] PEND_MAX = '1;
    localparam logic [SB_PW-1:0] PEND_ONE = SB_PW'(1);

    logic [SB_NREG-1:0][SB_PW-1:0] pend;
    logic [SB_NREG-1:0]            nz;
    logic [SB_NREG-1:0]            inc;
    logic [SB_NREG-1:0]            dec;

    logic [SB_PW-1:0] rs_pend, rt_pend, rd_pend;
    logic             rs_haz, rt_haz, rd_sat;
    logic             wb_live;
    logic             sb_err_q, sb_err_d;

    assign pend[0] = '0;
    assign nz[0]   = 1'b0;

    for (genvar r = 1; r < SB_NREG; r++) begin : g_cnt
        sb_pend_cnt #(.PW(SB_PW)) u_cnt (
            .clk   (clk),
            .rst   (rst),
            .clr_i (flush),
            .inc_i (inc[r]),
            .dec_i (dec[r]),
            .cnt_o (pend[r]),
            .nz_o  (nz[r])
        );
    end

    // A source whose last outstanding write lands this cycle is bypassed by the regfile.
    always_comb begin
        rs_pend = pend[iss_rs];
        rt_pend = pend[iss_rt];
        rd_pend = pend[iss_rd];
        rs_haz  = iss_rs_use && iss_rs != '0 && rs_pend != '0 &&
                  !(wb_wen && wb_waddr == iss_rs && rs_pend == PEND_ONE);
        rt_haz  = iss_rt_use && iss_rt != '0 && rt_pend != '0 &&
                  !(wb_wen && wb_waddr == iss_rt && rt_pend == PEND_ONE);
        rd_sat  = iss_wen && iss_rd != '0 && rd_pend == PEND_MAX &&
                  !(wb_wen && wb_waddr == iss_rd);
    end

    assign stall      = iss_valid && !flush && (rs_haz || rt_haz || rd_sat);
    assign iss_accept = iss_valid && !flush && !stall;
    assign wb_live    = wb_wen && !flush && wb_waddr != '0;

    always_comb begin
        inc = '0;
        dec = '0;
        for (int r = 1; r < SB_NREG; r++) begin
            inc[r] = iss_accept && iss_wen && iss_rd == SB_ASIZE'(r);
            dec[r] = wb_live && wb_waddr == SB_ASIZE'(r) && nz[r];
        end
    end

    // Writeback with nothing outstanding is a pipeline bug unless the same cycle issues it.
    always_comb begin
        sb_err_d = sb_err_q;
        if (wb_live && !nz[wb_waddr] &&
            !(iss_accept && iss_wen && iss_rd == wb_waddr)) begin
            sb_err_d = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            sb_err_q <= 1'b0;
        end else begin
            sb_err_q <= sb_err_d;
        end
    end

    assign busy   = nz;
    assign sb_err = sb_err_q;

`ifdef SCOREBOARD_STATS_EN
    logic [31:0] stall_cyc_q, stall_cyc_d;
    logic [31:0] issue_cnt_q, issue_cnt_d;

    assign stall_cyc_d = stall_cyc_q + 32'(stall);
    assign issue_cnt_d = issue_cnt_q + 32'(iss_accept);

    always_ff @(posedge clk) begin
        if (!rst) begin
            stall_cyc_q <= '0;
            issue_cnt_q <= '0;
        end else begin
            stall_cyc_q <= stall_cyc_d;
            issue_cnt_q <= issue_cnt_d;
        end
    end

    assign stat_stall_cyc = stall_cyc_q;
    assign stat_issue_cnt = issue_cnt_q;
`endif

endmodule

// File: tb/tb_regfile_scoreboard.sv
// Randomized and directed bench for regfile_scoreboard against a counting reference model.
module tb_regfile_scoreboard;
    import regfile_scoreboard_pkg::*;

    localparam int NR   = SB_NREG;
    localparam int AW   = SB_ASIZE;
    localparam int PMAX = (1 << SB_PW) - 1;

    logic          clk = 1'b0;
    logic          rst;
    logic          iss_valid, iss_rs_use, iss_rt_use, iss_wen, wb_wen, flush;
    logic [AW-1:0] iss_rs, iss_rt, iss_rd, wb_waddr;
    logic          stall, iss_accept, sb_err;
    logic [NR-1:0] busy;
`ifdef SCOREBOARD_STATS_EN
    logic [31:0]   stat_stall_cyc, stat_issue_cnt;
    int unsigned   m_stall_cyc, m_issue_cnt;
`endif

    always #5 clk = ~clk;

    regfile_scoreboard dut (
        .clk        (clk),
        .rst        (rst),
        .iss_valid  (iss_valid),
        .iss_rs_use (iss_rs_use),
        .iss_rs     (iss_rs),
        .iss_rt_use (iss_rt_use),
        .iss_rt     (iss_rt),
        .iss_wen    (iss_wen),
        .iss_rd     (iss_rd),
        .wb_wen     (wb_wen),
        .wb_waddr   (wb_waddr),
        .flush      (flush),
        .stall      (stall),
        .iss_accept (iss_accept),
        .busy       (busy),
        .sb_err     (sb_err)
`ifdef SCOREBOARD_STATS_EN
        ,
        .stat_stall_cyc (stat_stall_cyc),
        .stat_issue_cnt (stat_issue_cnt)
`endif
    );

    int pend_m [NR];
    bit err_m;
    int n_vec = 0;
    int n_bad = 0;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_vec++;
        if (obs !== exp) begin
            n_bad++;
            $display("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic logic [NR-1:0] model_busy();
        logic [NR-1:0] b;
        for (int i = 0; i < NR; i++) b[i] = (pend_m[i] != 0);
        return b;
    endfunction

    function automatic bit src_blocked(input logic use_, input int a, input logic wbw, input int wba);
        if (!use_ || a == 0 || pend_m[a] == 0) return 1'b0;
        if (wbw && wba == a && pend_m[a] == 1) return 1'b0;
        return 1'b1;
    endfunction

    // One clock: drive, check the combinational outputs, clock, update model, check state.
    task automatic cyc(input logic v, input logic rsu, input int rs, input logic rtu, input int rt,
                       input logic wn, input int rd, input logic wbw, input int wba,
                       input logic fl, input logic rstv);
        bit exp_stall, exp_acc;
        int nxt [NR];
        iss_valid  = v;   iss_rs_use = rsu; iss_rs = AW'(rs);
        iss_rt_use = rtu; iss_rt = AW'(rt); iss_wen = wn; iss_rd = AW'(rd);
        wb_wen = wbw; wb_waddr = AW'(wba); flush = fl; rst = rstv;
        #1;
        exp_stall = v && !fl && (src_blocked(rsu, rs, wbw, wba) || src_blocked(rtu, rt, wbw, wba) ||
                    (wn && rd != 0 && pend_m[rd] == PMAX && !(wbw && wba == rd)));
        exp_acc   = v && !fl && !exp_stall;
        check("stall", stall, exp_stall);
        check("iss_accept", iss_accept, exp_acc);
        @(posedge clk);
        if (!rstv) begin
            foreach (pend_m[i]) pend_m[i] = 0;
            err_m = 1'b0;
`ifdef SCOREBOARD_STATS_EN
            m_stall_cyc = 0;
            m_issue_cnt = 0;
`endif
        end else begin
`ifdef SCOREBOARD_STATS_EN
            m_stall_cyc += exp_stall;
            m_issue_cnt += exp_acc;
`endif
            if (fl) begin
                foreach (pend_m[i]) pend_m[i] = 0;
            end else begin
                nxt = pend_m;
                if (exp_acc && wn && rd != 0) nxt[rd]++;
                if (wbw && wba != 0) begin
                    if (pend_m[wba] != 0) nxt[wba]--;
                    else if (!(exp_acc && wn && rd == wba)) err_m = 1'b1;
                end
                pend_m = nxt;
            end
        end
        #1;
        check("busy", busy, model_busy());
        check("sb_err", sb_err, err_m);
`ifdef SCOREBOARD_STATS_EN
        check("stat_stall_cyc", stat_stall_cyc, m_stall_cyc);
        check("stat_issue_cnt", stat_issue_cnt, m_issue_cnt);
`endif
    endtask

    task automatic idle();
        cyc(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1);
    endtask

    task automatic do_reset();
        cyc(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    endtask

    initial begin
        foreach (pend_m[i]) pend_m[i] = 0;
        err_m = 1'b0;
`ifdef SCOREBOARD_STATS_EN
        m_stall_cyc = 0;
        m_issue_cnt = 0;
`endif
        @(posedge clk);
        #1;
        do_reset();
        check("rst_busy", busy, '0);
        check("rst_err", sb_err, 0);

        // Issue and retire a destination.
        cyc(1, 0, 0, 0, 0, 1, 3, 0, 0, 0, 1);
        check("t1_busy3_set", busy[3], 1);
        cyc(0, 0, 0, 0, 0, 0, 0, 1, 3, 0, 1);
        check("t1_busy3_clr", busy[3], 0);

        // RAW stall until the producing writeback, which bypasses.
        cyc(1, 0, 0, 0, 0, 1, 5, 0, 0, 0, 1);
        cyc(1, 1, 5, 0, 0, 0, 0, 0, 0, 0, 1);
        check("t2_stall_hold", stall, 1);
        cyc(1, 1, 5, 0, 0, 0, 0, 0, 0, 0, 1);
        cyc(1, 1, 5, 0, 0, 0, 0, 1, 5, 0, 1);
        check("t2_busy5_clr", busy[5], 0);

        // Destination saturation and its same-cycle-writeback escape.
        for (int k = 0; k < PMAX; k++) cyc(1, 0, 0, 0, 0, 1, 7, 0, 0, 0, 1);
        cyc(1, 0, 0, 0, 0, 1, 7, 0, 0, 0, 1);
        check("t3_sat_stall", stall, 1);
        cyc(1, 0, 0, 0, 0, 1, 7, 1, 7, 0, 1);
        cyc(1, 0, 0, 0, 0, 1, 7, 0, 0, 0, 1);
        check("t3_still_sat", stall, 1);

        // Same-cycle issue and writeback to one register holds the count.
        do_reset();
        cyc(1, 0, 0, 0, 0, 1, 2, 0, 0, 0, 1);
        cyc(1, 0, 0, 0, 0, 1, 2, 1, 2, 0, 1);
        check("t4_busy2", busy[2], 1);
        check("t4_err", sb_err, 0);
        cyc(0, 0, 0, 0, 0, 0, 0, 1, 2, 0, 1);
        check("t4_busy2_clr", busy[2], 0);

        // Spurious writeback sets the sticky error; reset clears it.
        cyc(0, 0, 0, 0, 0, 0, 0, 1, 9, 0, 1);
        check("t5_err_set", sb_err, 1);
        idle();
        check("t5_err_sticky", sb_err, 1);
        do_reset();
        check("t5_err_rst", sb_err, 0);

        // Flush discards everything and blocks the presented issue.
        cyc(1, 0, 0, 0, 0, 1, 1, 0, 0, 0, 1);
        cyc(1, 0, 0, 0, 0, 1, 4, 0, 0, 0, 1);
        cyc(1, 0, 0, 0, 0, 1, 6, 1, 1, 1, 1);
        check("t6_busy_flush", busy, '0);

        // Randomized traffic over a small register window to provoke hazards.
        for (int n = 0; n < 800; n++) begin
            cyc(($urandom % 4) != 0, $urandom % 2, $urandom % 8, $urandom % 2, $urandom % 8,
                ($urandom % 3) != 0, $urandom % 8, ($urandom % 3) == 0, $urandom % 8,
                ($urandom % 30) == 0, ($urandom % 50) != 0);
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: observed running expected finished");
        $fatal(1);
    end

endmodule
